// File: rtl/vga_reg_update_master.sv
// rtl/vga_reg_update_master.sv - queues register updates and replays them on the display bus during vertical blanking
// Optional feature macro: VGA_REG_IMMEDIATE_EN (adds the immediate input to drain outside blanking).
module vga_reg_update_master #(
  parameter int ADDR_W           = 9,
  parameter int DATA_W           = 32,
  parameter int FIFO_DEPTH       = 16,
  parameter int VACTIVE          = 480,
  parameter int MAX_WR_PER_FRAME = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [9:0]                    vcount,
`ifdef VGA_REG_IMMEDIATE_EN
  input  logic                          immediate,
`endif
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_data,
  output logic                          m_chipselect,
  output logic                          m_write,
  output logic [ADDR_W-1:0]             m_address,
  output logic [DATA_W-1:0]             m_writedata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done,
  output logic                          busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(MAX_WR_PER_FRAME + 1);
  localparam int ENT_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_next;

  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_ready_en;
  logic             r_in_blank_q;
  logic [CNT_W-1:0] r_wr_cnt;
  logic             w_in_blank, w_blank_rise, w_empty, w_full;
  logic             w_push, w_pop, w_cnt_clr, w_imm, w_cap_ok;
  logic [ENT_W-1:0] w_head;

`ifdef VGA_REG_IMMEDIATE_EN
  assign w_imm = immediate;
`else
  assign w_imm = 1'b0;
`endif

  assign w_in_blank   = (int'(vcount) >= VACTIVE);
  assign w_blank_rise = w_in_blank && !r_in_blank_q;
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
  assign w_cap_ok     = (r_wr_cnt < CNT_W'(MAX_WR_PER_FRAME));
  assign w_head       = r_mem[r_rd_ptr];

  // Ready is held low until the first clock after reset release, then tracks occupancy only.
  assign req_ready  = r_ready_en && !w_full;
  assign w_push     = req_valid && req_ready;
  assign fifo_level = r_count;
  assign frame_done = (r_state == S_DONE);
  assign busy       = (r_state == S_DRAIN);

  // Next-state and pop decision; a drain pops only while data, blanking (or immediate) and budget all allow.
  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_cnt_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_blank_rise || (w_imm && !w_empty)) begin
          w_next    = S_DRAIN;
          w_cnt_clr = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!w_empty && (w_in_blank || w_imm) && w_cap_ok) begin
          w_pop = 1'b1;
        end else begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, blank edge history, write budget and ready enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_in_blank_q <= 1'b0;
      r_wr_cnt     <= '0;
      r_ready_en   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_in_blank_q <= w_in_blank;
      r_ready_en   <= 1'b1;
      if (w_cnt_clr) begin
        r_wr_cnt <= '0;
      end else if (w_pop) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
    end
  end

  // Entry storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {req_addr, req_data};
    end
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy is kept exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered bus strobes: one cycle per popped entry, address/data zero when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
      m_address    <= '0;
      m_writedata  <= '0;
    end else begin
      m_chipselect <= w_pop;
      m_write      <= w_pop;
      m_address    <= w_pop ? w_head[ENT_W-1:DATA_W] : '0;
      m_writedata  <= w_pop ? w_head[DATA_W-1:0] : '0;
    end
  end
endmodule

// File: tb/tb_vga_reg_update_master.sv
// tb/tb_vga_reg_update_master.sv - self-checking bench for vga_reg_update_master (default cap and cap=4 instances)
module tb_vga_reg_update_master;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  vcount = 10'd0;
  logic        req_valid = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic        immediate = 1'b0;

  logic        rr [2];
  logic        cs [2];
  logic        wr [2];
  logic [8:0]  ad [2];
  logic [31:0] wd [2];
  logic [4:0]  lvl [2];
  logic        fd [2];
  logic        bz [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  vga_reg_update_master u_dut (
    .clk(clk), .reset_n(reset_n), .vcount(vcount),
`ifdef VGA_REG_IMMEDIATE_EN
    .immediate(immediate),
`endif
    .req_valid(req_valid), .req_ready(rr[0]), .req_addr(req_addr), .req_data(req_data),
    .m_chipselect(cs[0]), .m_write(wr[0]), .m_address(ad[0]), .m_writedata(wd[0]),
    .fifo_level(lvl[0]), .frame_done(fd[0]), .busy(bz[0])
  );

  vga_reg_update_master #(.MAX_WR_PER_FRAME(4)) u_cap (
    .clk(clk), .reset_n(reset_n), .vcount(vcount),
`ifdef VGA_REG_IMMEDIATE_EN
    .immediate(immediate),
`endif
    .req_valid(req_valid), .req_ready(rr[1]), .req_addr(req_addr), .req_data(req_data),
    .m_chipselect(cs[1]), .m_write(wr[1]), .m_address(ad[1]), .m_writedata(wd[1]),
    .fifo_level(lvl[1]), .frame_done(fd[1]), .busy(bz[1])
  );

  // Reference model: a queue of pending updates plus the drain rules, one copy per instance.
  logic [40:0] mq [2][64];
  int          mhead [2] = '{0, 0};
  int          mcnt  [2] = '{0, 0};
  int          phase [2] = '{0, 0};   // 0 waiting, 1 draining, 2 drain finished
  int          wcnt  [2] = '{0, 0};
  bit          bq    [2] = '{0, 0};
  bit          ren   [2] = '{0, 0};
  bit          ecs   [2] = '{0, 0};
  logic [8:0]  eaddr [2] = '{9'd0, 9'd0};
  logic [31:0] edata [2] = '{32'd0, 32'd0};

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge reset_n) begin : model
    bit inb, push_ok;
    int cap;
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        mhead[k] = 0; mcnt[k] = 0; phase[k] = 0; wcnt[k] = 0; bq[k] = 0; ren[k] = 0;
        ecs[k] = 0; eaddr[k] = '0; edata[k] = '0;
      end else begin
        cap = (k == 0) ? 32 : 4;
        inb = (vcount >= 10'd480);
        push_ok = req_valid && ren[k] && (mcnt[k] < 16);
        ecs[k] = 0; eaddr[k] = '0; edata[k] = '0;
        if (phase[k] == 0) begin
          if ((inb && !bq[k]) || (immediate && mcnt[k] > 0)) begin
            phase[k] = 1;
            wcnt[k] = 0;
          end
        end else if (phase[k] == 1) begin
          if (mcnt[k] > 0 && (inb || immediate) && wcnt[k] < cap) begin
            {eaddr[k], edata[k]} = mq[k][mhead[k]];
            mhead[k] = (mhead[k] + 1) % 64;
            mcnt[k]--;
            wcnt[k]++;
            ecs[k] = 1;
          end else begin
            phase[k] = 2;
          end
        end else begin
          phase[k] = 0;
        end
        if (push_ok) begin
          mq[k][(mhead[k] + mcnt[k]) % 64] = {req_addr, req_data};
          mcnt[k]++;
        end
        bq[k] = inb;
        ren[k] = 1;
      end
    end
  end

  // Write log for hand-checked ordering and timing.
  logic [8:0]  lg_a [2][256];
  logic [31:0] lg_d [2][256];
  int          lg_c [2][256];
  int          ln [2] = '{0, 0};
  int          n_fd [2] = '{0, 0};
  int          done_cyc [2] = '{0, 0};

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    logic [50:0] act, exp;
    for (int k = 0; k < 2; k++) begin
      act = {rr[k], cs[k], wr[k], ad[k], wd[k], lvl[k], fd[k], bz[k]};
      exp = {ren[k] && (mcnt[k] < 16), ecs[k], ecs[k], eaddr[k], edata[k], 5'(mcnt[k]),
             phase[k] == 2, phase[k] == 1};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL outputs inst%0d cyc %0d actual %h required %h", k, cyc, act, exp);
      end
      if (cs[k] === 1'b1 && ln[k] < 256) begin
        lg_a[k][ln[k]] = ad[k];
        lg_d[k][ln[k]] = wd[k];
        lg_c[k][ln[k]] = cyc;
        ln[k]++;
      end
      if (fd[k] === 1'b1) begin
        n_fd[k]++;
        done_cyc[k] = cyc;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [8:0] a, input logic [31:0] d);
    bit ok;
    int n;
    n = 0;
    req_valid = 1'b1; req_addr = a; req_data = d;
    do begin
      ok = rr[0];
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 100);
    chk("push_accepted", ok, 1);
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    vcount = 10'd100;
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic blank(input int len);
    vcount = 10'd479;
    tick(1);
    vcount = 10'd480;
    tick(len);
    vcount = 10'd100;
    tick(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int b0, b1, c0, f0;
    // Reset state
    tick(2);
    chk("reset_level", lvl[0], 0);
    chk("reset_ready", rr[0], 0);
    chk("reset_cs", cs[0], 0);
    vcount = 10'd100;
    reset_n = 1'b1;
    tick(1);
    chk("ready_after_release", rr[0], 1);

    // Three updates, drained in order at blank
    push(9'd0, 32'd120); push(9'd1, 32'd90); push(9'd8, 32'd300);
    tick(3);
    chk("idle_before_blank", cs[0], 0);
    chk("level_before_blank", lvl[0], 3);
    b0 = ln[0]; f0 = n_fd[0];
    vcount = 10'd479; tick(1);
    vcount = 10'd480; c0 = cyc;
    tick(20); vcount = 10'd100; tick(4);
    chk("t1_writes", ln[0] - b0, 3);
    chk("t1_a0", lg_a[0][b0], 0);   chk("t1_d0", lg_d[0][b0], 120);
    chk("t1_a1", lg_a[0][b0+1], 1); chk("t1_d1", lg_d[0][b0+1], 90);
    chk("t1_a2", lg_a[0][b0+2], 8); chk("t1_d2", lg_d[0][b0+2], 300);
    chk("t1_first_cyc", lg_c[0][b0], c0 + 2);
    chk("t1_second_cyc", lg_c[0][b0+1], c0 + 3);
    chk("t1_third_cyc", lg_c[0][b0+2], c0 + 4);
    chk("t1_done_cyc", done_cyc[0], c0 + 5);
    chk("t1_done_pulses", n_fd[0] - f0, 1);
    chk("t1_level_end", lvl[0], 0);

    // Fill to full; refused 17th push; full drain
    do_reset();
    for (int i = 0; i < 16; i++) push(9'(i), 32'h1000 + i);
    chk("t2_level_full", lvl[0], 16);
    chk("t2_ready_full", rr[0], 0);
    req_valid = 1'b1; req_addr = 9'h1ff; req_data = 32'hdead;
    tick(1);
    req_valid = 1'b0;
    chk("t2_refused", lvl[0], 16);
    b0 = ln[0]; b1 = ln[1];
    blank(24);
    chk("t2_writes", ln[0] - b0, 16);
    chk("t2_cap_writes", ln[1] - b1, 4);
    chk("t2_cap_left", lvl[1], 12);
    for (int i = 0; i < 16; i++) begin
      chk("t2_addr", lg_a[0][b0+i], i);
      chk("t2_data", lg_d[0][b0+i], 32'h1000 + i);
    end

    // Write cap: 4,4,2 on the capped instance; empty blanks still pulse frame_done
    do_reset();
    for (int i = 0; i < 10; i++) push(9'(20 + i), 32'h2000 + i);
    b1 = ln[1];
    for (int b = 0; b < 3; b++) begin
      b0 = ln[0]; c0 = ln[1]; f0 = n_fd[0];
      blank(24);
      chk("t3_cap_per_blank", ln[1] - c0, (b < 2) ? 4 : 2);
      chk("t3_full_per_blank", ln[0] - b0, (b == 0) ? 10 : 0);
      chk("t3_done_pulse", n_fd[0] - f0, 1);
    end
    for (int i = 0; i < 10; i++) chk("t3_cap_order", lg_d[1][b1+i], 32'h2000 + i);

    // Blanking ends after two writes; remainder drains next frame, stream keeps feeding
    do_reset();
    for (int i = 0; i < 16; i++) push(9'(i), 32'h3000 + i);
    b0 = ln[0];
    fork
      begin
        vcount = 10'd480;
        tick(3);
        vcount = 10'd0;
        tick(6);
        chk("t4_first_blank_writes", ln[0] - b0, 2);
        vcount = 10'd479; tick(1);
        vcount = 10'd480; tick(40);
        vcount = 10'd100; tick(4);
      end
      begin
        for (int i = 16; i < 20; i++) push(9'(i), 32'h3000 + i);
      end
    join
    chk("t4_total_writes", ln[0] - b0, 20);
    for (int i = 0; i < 20; i++) chk("t4_order", lg_d[0][b0+i], 32'h3000 + i);

    // Reset during the second write of a drain
    do_reset();
    for (int i = 0; i < 3; i++) push(9'(40 + i), 32'h4000 + i);
    vcount = 10'd479; tick(1);
    vcount = 10'd480; tick(3);
    chk("t5_second_strobe", cs[0], 1);
    #3 reset_n = 1'b0;
    #1;
    chk("t5_cs_reset", cs[0], 0);
    chk("t5_addr_reset", ad[0], 0);
    chk("t5_level_reset", lvl[0], 0);
    tick(1);
    reset_n = 1'b1;
    b0 = ln[0]; b1 = ln[1];
    tick(10); vcount = 10'd100; tick(3);
    blank(10);
    chk("t5_no_writes", ln[0] - b0, 0);
    chk("t5_no_writes_cap", ln[1] - b1, 0);

`ifdef VGA_REG_IMMEDIATE_EN
    // Immediate mode writes outside blanking
    do_reset();
    immediate = 1'b1;
    vcount = 10'd50;
    b0 = ln[0];
    push(9'd5, 32'd555);
    c0 = cyc;
    tick(5);
    chk("t6_written", ln[0] - b0, 1);
    chk("t6_latency_ok", (lg_c[0][b0] - c0) <= 3, 1);
    immediate = 1'b0;
    tick(3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
